// File: rtl/trng_sim_entropy.sv
// trng_sim_entropy: simulation-only programmable entropy source (pattern / LFSR / counter words)
// delivered over the valid/ack handshake, with a repetition detector driving security_error.
module trng_sim_entropy #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter logic [15:0] RATE_DEFAULT    = 16'h0004,
  parameter logic [31:0] PATTERN_DEFAULT = 32'haa55aa55,
  parameter int unsigned REP_LIMIT       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic [7:0]            address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  error,
  input  logic                  test_mode,
  output logic                  security_error,
  output logic                  entropy_enabled,
  output logic [DATA_WIDTH-1:0] entropy_data,
  output logic                  entropy_valid,
  input  logic                  entropy_ack,
  output logic [7:0]            debug,
  input  logic                  debug_update
);

  localparam int unsigned       NUM_CHUNKS  = DATA_WIDTH / 32;
  localparam int unsigned       CIDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK  = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [3:0]        REP_LIMIT_V = 4'(REP_LIMIT);

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_RATE    = 8'h0a;
  localparam logic [7:0] ADDR_SEED    = 8'h0b;
  localparam logic [7:0] ADDR_PATTERN = 8'h0c;
  localparam logic [7:0] ADDR_WORDCNT = 8'h0d;

  localparam logic [1:0] MODE_PATTERN = 2'd0;
  localparam logic [1:0] MODE_COUNTER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_VALID   = 2'd3
  } state_t;

  // Galois step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {s[30:0], 1'b0} ^ (s[31] ? 32'h00400007 : 32'h00000000);
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  ctrl_enable_r;
  logic [1:0]            ctrl_mode_r;
  logic [15:0]           rate_r;
  logic [31:0]           pattern_r;
  logic [31:0]           lfsr_r;
  logic [31:0]           counter_r;
  logic [31:0]           wordcnt_r;
  logic [15:0]           timer_r;
  logic [CIDX_W-1:0]     chunk_idx_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] prev_r;
  logic                  have_prev_r;
  logic [3:0]            rep_r;
  logic                  sec_err_r;
  logic [7:0]            last_byte_r;
  logic [7:0]            debug_r;

  logic                  wr_s;
  logic                  ctrl_wr_s;
  logic                  status_clr_s;
  logic                  rate_wr_s;
  logic                  seed_wr_s;
  logic                  pattern_wr_s;
  logic [31:0]           lfsr_step_s;
  logic [31:0]           chunk_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [3:0]            rep_nxt_s;
  logic                  valid_s;
  logic                  collect_s;
  logic                  last_chunk_s;
  logic                  complete_s;
  logic                  ack_s;
  logic                  load_timer_s;
  logic [31:0]           rd_mux_s;
  logic                  addr_ok_s;

  // Register write decode
  always_comb begin
    wr_s         = cs && we;
    ctrl_wr_s    = wr_s && (address == ADDR_CTRL);
    status_clr_s = wr_s && (address == ADDR_STATUS) && write_data[1];
    rate_wr_s    = wr_s && (address == ADDR_RATE);
    seed_wr_s    = wr_s && (address == ADDR_SEED);
    pattern_wr_s = wr_s && (address == ADDR_PATTERN);
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_enable_r <= 1'b1;
      ctrl_mode_r   <= 2'd1;
      rate_r        <= RATE_DEFAULT;
      pattern_r     <= PATTERN_DEFAULT;
    end else begin
      if (ctrl_wr_s) begin
        ctrl_enable_r <= write_data[0];
        ctrl_mode_r   <= write_data[2:1];
      end
      if (rate_wr_s) begin
        rate_r <= write_data[15:0];
      end
      if (pattern_wr_s) begin
        pattern_r <= write_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a cleared enable always falls back to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!ctrl_enable_r) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_WAIT;
        ST_WAIT: begin
          if (timer_r == 16'h0000) state_nxt_s = ST_COLLECT;
          else                     state_nxt_s = ST_WAIT;
        end
        ST_COLLECT: begin
          if (last_chunk_s) state_nxt_s = ST_VALID;
          else              state_nxt_s = ST_COLLECT;
        end
        ST_VALID: begin
          if (entropy_ack) state_nxt_s = ST_WAIT;
          else             state_nxt_s = ST_VALID;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode
  always_comb begin
    valid_s      = (state_r == ST_VALID);
    collect_s    = (state_r == ST_COLLECT) && ctrl_enable_r;
    last_chunk_s = (chunk_idx_r == LAST_CHUNK);
    complete_s   = collect_s && last_chunk_s;
    ack_s        = valid_s && ctrl_enable_r && entropy_ack;
    load_timer_s = ctrl_enable_r && ((state_r == ST_IDLE) || ack_s);
  end

  // Chunk source selection; mode 3 behaves as LFSR
  always_comb begin
    lfsr_step_s = lfsr_step(lfsr_r);
    case (ctrl_mode_r)
      MODE_PATTERN: chunk_s = pattern_r;
      MODE_COUNTER: chunk_s = counter_r;
      default:      chunk_s = lfsr_step_s;
    endcase
  end

  // Inter-word idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 16'h0000;
    end else if (load_timer_s) begin
      timer_r <= rate_r;
    end else if ((state_r == ST_WAIT) && (timer_r != 16'h0000)) begin
      timer_r <= timer_r - 16'h0001;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Generator state; a SEED write overrides the same-cycle LFSR step
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r    <= 32'h00000001;
      counter_r <= 32'h00000000;
    end else begin
      if (seed_wr_s) begin
        lfsr_r <= (write_data == 32'h00000000) ? 32'h00000001 : write_data;
      end else if (collect_s && (ctrl_mode_r != MODE_PATTERN) && (ctrl_mode_r != MODE_COUNTER)) begin
        lfsr_r <= lfsr_step_s;
      end
      if (collect_s && (ctrl_mode_r == MODE_COUNTER)) begin
        counter_r <= counter_r + 32'h00000001;
      end
    end
  end

  // Word assembly, least significant chunk first; leaving COLLECT restarts at chunk 0
  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_idx_r <= {CIDX_W{1'b0}};
      data_r      <= {DATA_WIDTH{1'b0}};
    end else if (collect_s) begin
      chunk_idx_r <= last_chunk_s ? {CIDX_W{1'b0}} : chunk_idx_r + CIDX_W'(1);
      for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
        if (chunk_idx_r == CIDX_W'(k)) data_r[32*k +: 32] <= chunk_s;
      end
    end else begin
      chunk_idx_r <= {CIDX_W{1'b0}};
    end
  end

  // Completed word and next repetition count
  always_comb begin
    word_s = data_r;
    word_s[DATA_WIDTH-32 +: 32] = chunk_s;
    if (have_prev_r && (word_s == prev_r)) begin
      if (rep_r == 4'hf) rep_nxt_s = 4'hf;
      else               rep_nxt_s = rep_r + 4'h1;
    end else begin
      rep_nxt_s = 4'h1;
    end
  end

  // Repetition detector; a same-cycle detection beats the STATUS clear
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r      <= {DATA_WIDTH{1'b0}};
      have_prev_r <= 1'b0;
      rep_r       <= 4'h0;
      sec_err_r   <= 1'b0;
    end else begin
      if (complete_s) begin
        prev_r      <= word_s;
        have_prev_r <= 1'b1;
        rep_r       <= rep_nxt_s;
      end else if (status_clr_s) begin
        rep_r <= 4'h0;
      end
      if (complete_s && !test_mode && (rep_nxt_s >= REP_LIMIT_V)) begin
        sec_err_r <= 1'b1;
      end else if (status_clr_s) begin
        sec_err_r <= 1'b0;
      end
    end
  end

  // Acked-word counter and debug latch
  always_ff @(posedge clk) begin
    if (reset) begin
      wordcnt_r   <= 32'h00000000;
      last_byte_r <= 8'h00;
      debug_r     <= 8'h00;
    end else begin
      if (ack_s) begin
        wordcnt_r   <= wordcnt_r + 32'h00000001;
        last_byte_r <= data_r[7:0];
      end
      if (debug_update) begin
        debug_r <= ack_s ? data_r[7:0] : last_byte_r;
      end
    end
  end

  // Register read mux and access error
  always_comb begin
    rd_mux_s  = 32'h00000000;
    addr_ok_s = 1'b1;
    case (address)
      ADDR_CTRL:    rd_mux_s = {29'h0, ctrl_mode_r, ctrl_enable_r};
      ADDR_STATUS:  rd_mux_s = {30'h0, sec_err_r, valid_s};
      ADDR_RATE:    rd_mux_s = {16'h0000, rate_r};
      ADDR_SEED:    rd_mux_s = lfsr_r;
      ADDR_PATTERN: rd_mux_s = pattern_r;
      ADDR_WORDCNT: rd_mux_s = wordcnt_r;
      default:      addr_ok_s = 1'b0;
    endcase
    if (cs && !we) read_data = rd_mux_s;
    else           read_data = 32'h00000000;
    error = cs && (!addr_ok_s || (we && (address == ADDR_WORDCNT)));
  end

  assign security_error  = sec_err_r;
  assign entropy_enabled = ctrl_enable_r;
  assign entropy_data    = data_r;
  assign entropy_valid   = valid_s;
  assign debug           = debug_r;

endmodule

// File: tb/tb_trng_sim_entropy.sv
// Directed self-checking bench for trng_sim_entropy (64-bit words, REP_LIMIT 4).
module tb_trng_sim_entropy;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    address = 8'h00;
  logic [31:0]   write_data = 32'h0;
  logic [31:0]   read_data;
  logic          error;
  logic          test_mode = 1'b0;
  logic          security_error;
  logic          entropy_enabled;
  logic [DW-1:0] entropy_data;
  logic          entropy_valid;
  logic          entropy_ack = 1'b0;
  logic [7:0]    debug;
  logic          debug_update = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trng_sim_entropy #(
    .DATA_WIDTH(DW),
    .RATE_DEFAULT(16'h0004),
    .PATTERN_DEFAULT(32'haa55aa55),
    .REP_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .we(we),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .error(error),
    .test_mode(test_mode),
    .security_error(security_error),
    .entropy_enabled(entropy_enabled),
    .entropy_data(entropy_data),
    .entropy_valid(entropy_valid),
    .entropy_ack(entropy_ack),
    .debug(debug),
    .debug_update(debug_update)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    check(tag, 64'(read_data), 64'(exp));
    cs = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!entropy_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic ack();
    entropy_ack = 1'b1;
    tick();
    entropy_ack = 1'b0;
  endtask

  initial begin
    int last_rise;
    int rises;
    int consec;
    logic prev_v;
    logic seen_v;

    // Reset state
    tick(); tick();
    check("rst_valid", 64'(entropy_valid), 64'd0);
    check("rst_sec", 64'(security_error), 64'd0);
    check("rst_enabled", 64'(entropy_enabled), 64'd1);
    check("rst_debug", 64'(debug), 64'd0);
    check("rst_data", entropy_data, 64'd0);
    read_check("rst_ctrl", 8'h08, 32'h00000003);
    read_check("rst_rate", 8'h0a, 32'h00000004);
    read_check("rst_seed", 8'h0b, 32'h00000001);
    read_check("rst_pattern", 8'h0c, 32'haa55aa55);
    read_check("rst_wordcnt", 8'h0d, 32'h00000000);
    read_check("rst_status", 8'h09, 32'h00000000);

    // LFSR words from reset: 1 + (4+1) + 2 cycles to first valid
    reset = 1'b0;
    wait_valid("first_latency", 8);
    check("lfsr_w1", entropy_data, 64'h00000004_00000002);
    read_check("status_valid", 8'h09, 32'h00000001);
    ack();
    check("valid_drop_on_ack", 64'(entropy_valid), 64'd0);
    wait_valid("ack_to_valid", 7);
    check("lfsr_w2", entropy_data, 64'h00000010_00000008);
    debug_update = 1'b1;
    tick();
    debug_update = 1'b0;
    check("debug_latch", 64'(debug), 64'h02);
    ack();
    check("debug_hold", 64'(debug), 64'h02);
    read_check("wordcnt_2", 8'h0d, 32'h00000002);

    // Seeded LFSR with RATE=0
    reg_write(8'h08, 32'h00000002);
    check("disabled_valid", 64'(entropy_valid), 64'd0);
    reg_write(8'h0b, 32'h80000000);
    reg_write(8'h0a, 32'h00000000);
    reg_write(8'h08, 32'h00000003);
    wait_valid("seed_latency", 4);
    check("seed_word", entropy_data, 64'h0080000e_00400007);
    reg_write(8'h0b, 32'h00000000);
    read_check("seed_zero", 8'h0b, 32'h00000001);

    // Reset while a word is valid
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(entropy_valid), 64'd0);
    check("midrst_data", entropy_data, 64'd0);
    check("midrst_debug", 64'(debug), 64'd0);
    check("midrst_enabled", 64'(entropy_enabled), 64'd1);
    read_check("midrst_wordcnt", 8'h0d, 32'h00000000);
    reset = 1'b0;

    // Counter mode
    reg_write(8'h08, 32'h00000004);
    reg_write(8'h0a, 32'h00000000);
    reg_write(8'h08, 32'h00000005);
    wait_valid("cnt_latency", 4);
    check("cnt_w1", entropy_data, 64'h00000001_00000000);
    ack();
    wait_valid("cnt_spacing", 3);
    check("cnt_w2", entropy_data, 64'h00000003_00000002);
    ack();
    read_check("cnt_wordcnt", 8'h0d, 32'h00000002);

    // Pattern mode repetition detector
    reg_write(8'h08, 32'h00000000);
    reg_write(8'h08, 32'h00000001);
    for (int w = 1; w <= 4; w++) begin
      if (w > 1) begin
        ack();
        wait_valid("pat_spacing", 3);
      end else begin
        wait_valid("pat_latency", 4);
      end
      check("pat_word", entropy_data, {2{32'haa55aa55}});
      check("sec_err_rise", 64'(security_error), (w == 4) ? 64'd1 : 64'd0);
    end
    read_check("status_sec", 8'h09, 32'h00000003);
    reg_write(8'h09, 32'h00000002);
    check("sec_clear", 64'(security_error), 64'd0);
    read_check("status_cleared", 8'h09, 32'h00000001);
    test_mode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      ack();
      wait_valid("tm_spacing", 3);
      check("tm_sec", 64'(security_error), 64'd0);
    end

    // RATE=5 with ack held high
    reg_write(8'h0a, 32'h00000005);
    entropy_ack = 1'b1;
    last_rise = -1;
    rises = 0;
    consec = 0;
    prev_v = entropy_valid;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (entropy_valid && prev_v) consec++;
      if (entropy_valid) begin
        if (last_rise < 0) check("rate_first", 64'(i), 64'd9);
        else               check("rate_spacing", 64'(i - last_rise), 64'd9);
        last_rise = i;
        rises++;
      end
      prev_v = entropy_valid;
    end
    entropy_ack = 1'b0;
    check("rate_rises", 64'(rises), 64'd4);
    check("rate_consec", 64'(consec), 64'd0);
    read_check("rate_wordcnt", 8'h0d, 32'd15);

    // Enable cleared after the first chunk of a counter word
    reg_write(8'h08, 32'h00000004);
    reg_write(8'h08, 32'h00000005);
    repeat (7) tick();
    reg_write(8'h08, 32'h00000004);
    seen_v = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (entropy_valid) seen_v = 1'b1;
    end
    check("midcollect_valid", 64'(seen_v), 64'd0);
    reg_write(8'h0a, 32'h00000000);
    reg_write(8'h08, 32'h00000005);
    wait_valid("restart_latency", 4);
    check("restart_word", entropy_data, 64'h00000006_00000005);

    // Access errors
    cs = 1'b1; we = 1'b0; address = 8'h07;
    #1;
    check("unmapped_err", 64'(error), 64'd1);
    check("unmapped_rd", 64'(read_data), 64'd0);
    cs = 1'b1; we = 1'b1; address = 8'h0d; write_data = 32'h0000abcd;
    #1;
    check("ro_write_err", 64'(error), 64'd1);
    check("ro_write_rd", 64'(read_data), 64'd0);
    tick();
    cs = 1'b1; we = 1'b1; address = 8'h0b; write_data = 32'h00000000;
    #1;
    check("seed_write_err", 64'(error), 64'd0);
    cs = 1'b0; we = 1'b0; address = 8'h08;
    #1;
    check("nocs_rd", 64'(read_data), 64'd0);
    read_check("wordcnt_after_ro", 8'h0d, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trng_sim_entropy.md
# trng_sim_entropy

Parametrised simulation-only entropy source for TRNG bench builds: a drop-in replacement for a physical entropy provider that delivers deterministic, programmable words over the standard valid/ack entropy handshake. It extends the constant-output stub model with:

- word width wider than 32 bits;
- three data modes (fixed pattern, LFSR, counter);
- a programmable word rate;
- a repetition detector that drives `security_error`, so the mixer's health and error paths can be exercised.

It provides no real entropy and must never be synthesised into a product build.

## Interface
- `DATA_WIDTH`, 32: entropy word width; multiple of 32, 32..256; N = DATA_WIDTH/32 chunks per word.
- `RATE_DEFAULT`, 16'h0004: reset value of the RATE register.
- `PATTERN_DEFAULT`, 32'haa55aa55: reset value of the PATTERN register.
- `REP_LIMIT`, 4: consecutive identical words that trigger `security_error`; 2..15.
- `clk` in 1: sole clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cs`, `we` in 1: register access strobe and write enable.
- `address` in 8: register address.
- `write_data` in 32: register write data.
- `read_data` out 32: combinational read data; 0 when `cs`=0.
- `error` out 1: combinational; `cs` and (unmapped address, or write to a read-only register).
- `test_mode` in 1: 1 suppresses setting of `security_error`.
- `security_error` out 1: sticky repetition flag.
- `entropy_enabled` out 1: mirror of CTRL.enable.
- `entropy_data` out DATA_WIDTH: held word, valid while `entropy_valid`.
- `entropy_valid` out 1: word available.
- `entropy_ack` in 1: consumer accepts the word.
- `debug` out 8: low byte of the last acked word, latched on `debug_update`.
- `debug_update` in 1: debug latch strobe.

## Operation

**Registers**
- 0x08 CTRL (rw)
  - bit0 enable, reset 1.
  - bits[2:1] mode, reset 1: 0 = pattern, 1 = LFSR, 2 = counter, 3 = treated as LFSR.
- 0x09 STATUS
  - Read: bit0 = `entropy_valid`, bit1 = `security_error`.
  - Write: 1 to bit1 clears the flag and the repetition count.
- 0x0a RATE (rw, bits[15:0]): idle cycles between words.
- 0x0b SEED (wo): loads the LFSR; a written value of 0 loads 1.
  - Read returns the current LFSR state.
  - Writes are not treated as errors.
- 0x0c PATTERN (rw).
- 0x0d WORDCNT (ro): count of acked words, 32-bit, wraps.

**Reset values**
- LFSR = 1, chunk counter = 0, WORDCNT = 0.
- All outputs 0 except `entropy_enabled` = 1.

**LFSR**
- 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
- Step: next = {s[30:0],0} ^ (s[31] ? 32'h00400007 : 0).
- The chunk is the post-step state.

**Chunks by mode**
- Pattern mode: chunk = PATTERN.
- Counter mode: chunk = counter, then counter+1 (32-bit wrap).
- Chunk k (0-based) is placed at bits [32k+31:32k]; the first chunk is least significant.

**FSM**
- IDLE: if enable, go to WAIT with timer = RATE.
- WAIT: decrement the timer each cycle; at 0 go to COLLECT. RATE=0 means one WAIT cycle.
- COLLECT: one chunk per cycle for N cycles, then go to VALID.
- VALID: `entropy_valid`=1 and `entropy_data` held. On `entropy_ack`: WORDCNT+1, go to WAIT with timer = RATE.

**Enable**
- enable=0 in any state: next cycle IDLE, `entropy_valid`=0, partial word discarded.
- LFSR and counter state are retained.

**Repetition detector**
- Runs on each word completion (COLLECT to VALID).
- If a previous word exists and the new word equals it: rep count +1, saturating at 15. Otherwise rep count = 1.
- If rep count reaches REP_LIMIT and `test_mode`=0: `security_error` is set and stays set until cleared by STATUS write or reset.
- The first word after reset sets rep count = 1 with no comparison.

## Timing
- `read_data` and `error` are combinational on the same cycle as `cs`; writes take effect at the next edge.
- First valid after reset release: 1 (IDLE) + (RATE+1) (WAIT) + N (COLLECT) cycles. `entropy_valid` rises on the following edge.
- Ack sampled at edge k: `entropy_valid`=0 from k. The next `entropy_valid` rises at k + RATE + 1 + N.
- `entropy_ack` while `entropy_valid`=0 is ignored.
- A RATE, PATTERN or mode write takes effect from the next WAIT load or chunk; the current word is unaffected.
- A SEED write during COLLECT takes priority over that cycle's LFSR step.
- STATUS clear and detector set in the same cycle: the set wins.
- `debug` updates on the edge after `debug_update`=1; it holds 0 until the first ack.

## Test plan
- DATA_WIDTH=64, reset, mode=LFSR, SEED=1, RATE=0 → first word 64'h00000004_00000002, valid 2+1+2 cycles after SEED write completes.
- SEED=32'h80000000, DATA_WIDTH=32 → word 32'h00400007; SEED write of 0 → readback 1.
- Counter mode, DATA_WIDTH=64, ack each word → 64'h00000001_00000000, then 64'h00000003_00000002; WORDCNT=2.
- Pattern mode, PATTERN=32'haa55aa55, REP_LIMIT=4, `test_mode`=0 → `security_error` rises on the 4th word completion; STATUS write 2 clears it. Repeat with `test_mode`=1 → never set.
- RATE=5, ack held high → valid spacing of 5+1+N+1 cycles; `entropy_valid` never high for 2 consecutive cycles.
- enable cleared mid-COLLECT → valid stays 0. Reads at 0x07 or a write to 0x0d → `error`=1, `read_data`=0. Reset mid-VALID → all outputs at reset values on the next cycle.
